// File: rtl/pulp_io_event_collector_pkg.sv
// Shared constants and types for the IO event collector.
package io_evt_pkg;

  localparam int unsigned N_CH        = 32;
  localparam int unsigned N_EV_PER_CH = 4;
  localparam int unsigned N_LINES     = N_CH * N_EV_PER_CH;
  localparam int unsigned ID_WIDTH    = 8;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned LOST_CNT_W  = 16;

  typedef logic [ID_WIDTH-1:0] evt_id_t;

endpackage

// File: rtl/pulp_io_event_collector_if.sv
// Event ID stream towards the SoC event unit (valid/ready, show-ahead head).
interface pulp_io_event_collector_if #(
  parameter int unsigned ID_WIDTH = io_evt_pkg::ID_WIDTH
) ();

  logic                evt_valid_o;
  logic [ID_WIDTH-1:0] evt_id_o;
  logic                evt_ready_i;

  modport master (output evt_valid_o, output evt_id_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_id_o, output evt_ready_i);

endinterface

// File: rtl/pulp_io_event_collector_fifo.sv
// Synchronous show-ahead FIFO; head is presented combinationally, zero when empty.
module io_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // a full FIFO refuses pushes even when it pops in the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  // pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // head presentation
  always_comb begin
    data_o = '0;
    if (!empty_o) data_o = mem[rd_q];
  end

endmodule

// File: rtl/pulp_io_event_collector.sv
// IO event collector: latches uDMA event pulses into pending bits, grants them
// round-robin into an ID FIFO and streams IDs out.
// Optional: IO_EVT_LOST_CNT_EN enables the saturating lost-event counter.
module pulp_io_event_collector #(
  parameter int unsigned N_CH        = io_evt_pkg::N_CH,
  parameter int unsigned N_EV_PER_CH = io_evt_pkg::N_EV_PER_CH,
  parameter int unsigned FIFO_DEPTH  = io_evt_pkg::FIFO_DEPTH,
  parameter int unsigned ID_WIDTH    = io_evt_pkg::ID_WIDTH
) (
  input  logic                                   sys_clk_i,
  input  logic                                   sys_rst_ni,
  input  logic [N_CH-1:0][N_EV_PER_CH-1:0]       events_i,
  input  logic [N_CH*N_EV_PER_CH-1:0]            mask_i,
  pulp_io_event_collector_if.master              evt,
  output logic                                   lost_o,
  input  logic                                   lost_clr_i,
  output logic [io_evt_pkg::LOST_CNT_W-1:0]      lost_cnt_o
);

  import io_evt_pkg::*;

  localparam int unsigned NL = N_CH * N_EV_PER_CH;
  localparam int unsigned LW = $clog2(NL);

  typedef logic [ID_WIDTH-1:0] id_t;

  logic [NL-1:0] pend_q, hit, grant, lost_vec;
  logic [LW-1:0] rr_q, win_idx;
  logic          win_vld, push, fifo_full, fifo_empty;
  int unsigned   idx;

  // packed [ch][ev] flattens to bit ch*N_EV_PER_CH+ev
  assign hit = events_i & mask_i;

  // round-robin search starting at rr_q
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NL; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NL) idx = idx - NL;
      if (!win_vld && pend_q[idx]) begin
        win_vld = 1'b1;
        win_idx = LW'(idx);
      end
    end
  end

  assign push = win_vld & ~fifo_full;

  // one-hot grant and losses (a pulse on the line being granted is retained)
  always_comb begin
    grant = '0;
    if (push) grant[win_idx] = 1'b1;
    lost_vec = hit & pend_q & ~grant;
  end

  // pending bits, rr pointer and sticky loss flag
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pend_q <= '0;
      rr_q   <= '0;
      lost_o <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~grant) | hit;
      if (push) rr_q <= (win_idx == LW'(NL-1)) ? '0 : win_idx + LW'(1);
      if (|lost_vec)       lost_o <= 1'b1;
      else if (lost_clr_i) lost_o <= 1'b0;
    end
  end

`ifdef IO_EVT_LOST_CNT_EN
  logic [LOST_CNT_W:0] cnt_sum;

  // clear restarts from zero, so same-cycle losses still count
  always_comb begin
    cnt_sum = (LOST_CNT_W+1)'($countones(lost_vec));
    if (!lost_clr_i) cnt_sum = cnt_sum + {1'b0, lost_cnt_o};
  end

  // saturating lost-event counter
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni)             lost_cnt_o <= '0;
    else if (cnt_sum[LOST_CNT_W]) lost_cnt_o <= '1;
    else                          lost_cnt_o <= cnt_sum[LOST_CNT_W-1:0];
  end
`else
  assign lost_cnt_o = '0;
`endif

  io_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (id_t)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rst_ni),
    .push_i  (push),
    .data_i  (id_t'(win_idx)),
    .full_o  (fifo_full),
    .pop_i   (evt.evt_ready_i),
    .data_o  (evt.evt_id_o),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_pulp_io_event_collector.sv
// Bench for pulp_io_event_collector: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pulp_io_event_collector;

  import io_evt_pkg::*;

  logic                                 clk = 1'b0;
  logic                                 rst_n;
  logic [N_CH-1:0][N_EV_PER_CH-1:0]     events;
  logic [N_LINES-1:0]                   mask;
  logic                                 lost, lost_clr;
  logic [LOST_CNT_W-1:0]                lost_cnt;

  pulp_io_event_collector_if evt_if ();

  pulp_io_event_collector #(
    .N_CH        (N_CH),
    .N_EV_PER_CH (N_EV_PER_CH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ID_WIDTH    (ID_WIDTH)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .events_i   (events),
    .mask_i     (mask),
    .evt        (evt_if),
    .lost_o     (lost),
    .lost_clr_i (lost_clr),
    .lost_cnt_o (lost_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // reference model state
  bit          m_pend [N_LINES];
  int unsigned m_rr;
  int unsigned m_q [$];
  bit          m_lost;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[l]) m_pend[l] = 1'b0;
    m_rr   = 0;
    m_q.delete();
    m_lost = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_tick();
    bit          hit [N_LINES];
    bit          found = 1'b0;
    int unsigned w = 0;
    int unsigned nloss = 0;
    bit          pop;
    if (m_q.size() < FIFO_DEPTH) begin
      for (int unsigned i = 0; i < N_LINES; i++) begin
        int unsigned l = (m_rr + i) % N_LINES;
        if (!found && m_pend[l]) begin
          found = 1'b1;
          w = l;
        end
      end
    end
    for (int unsigned l = 0; l < N_LINES; l++) begin
      hit[l] = events[l / N_EV_PER_CH][l % N_EV_PER_CH] && mask[l];
      if (hit[l] && m_pend[l] && !(found && l == w)) nloss++;
    end
    pop = (m_q.size() > 0) && evt_if.evt_ready_i;
    if (found) m_pend[w] = 1'b0;
    for (int unsigned l = 0; l < N_LINES; l++) if (hit[l]) m_pend[l] = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (found) begin
      m_q.push_back(w);
      m_rr = (w + 1) % N_LINES;
    end
    if (nloss > 0)     m_lost = 1'b1;
    else if (lost_clr) m_lost = 1'b0;
    if (lost_clr) m_cnt = nloss;
    else          m_cnt = m_cnt + nloss;
    if (m_cnt > 16'hFFFF) m_cnt = 16'hFFFF;
  endtask

  // compare at the falling edge, advance the model at the rising edge,
  // then retire single-cycle inputs just after it
  task automatic step();
    int unsigned exp_cnt;
    @(negedge clk);
    check("valid", evt_if.evt_valid_o, m_q.size() > 0);
    check("id", evt_if.evt_id_o, (m_q.size() > 0) ? m_q[0] : 0);
    check("lost", lost, m_lost);
`ifdef IO_EVT_LOST_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("lost_cnt", lost_cnt, exp_cnt);
    @(posedge clk);
    if (rst_n) model_tick();
    else       model_reset();
    #1;
    events   = '0;
    lost_clr = 1'b0;
  endtask

  task automatic pulse(input int unsigned l);
    events[l / N_EV_PER_CH][l % N_EV_PER_CH] = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    events   = '0;
    mask     = '1;
    lost_clr = 1'b0;
    evt_if.evt_ready_i = 1'b1;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single pulse on [3][2] -> ID 14 two cycles later
    pulse(14);
    repeat (5) step();

    // same-cycle burst with rr at 15, then lines 0/5 after rr moved past 0
    pulse(0); pulse(5); pulse(127);
    repeat (6) step();
    pulse(0); pulse(5);
    repeat (6) step();

    // back-pressure: 10 lines, 8 queue and 2 stay pending
    evt_if.evt_ready_i = 1'b0;
    for (int unsigned i = 0; i < 10; i++) pulse(30 + 3 * i);
    repeat (14) step();
    evt_if.evt_ready_i = 1'b1;
    repeat (14) step();

    // repeat on a pending line while the FIFO is full -> loss
    evt_if.evt_ready_i = 1'b0;
    for (int unsigned i = 0; i < 8; i++) pulse(40 + i);
    repeat (10) step();
    pulse(20);
    repeat (3) step();
    pulse(20);
    repeat (3) step();
    evt_if.evt_ready_i = 1'b1;
    repeat (14) step();
    lost_clr = 1'b1;
    repeat (3) step();

    // masked line ignored; pulse during its own grant is retained
    mask[7] = 1'b0;
    pulse(7);
    repeat (4) step();
    mask[7] = 1'b1;
    pulse(7);
    step();
    pulse(7);
    repeat (6) step();

    // reset in the middle of a drain
    evt_if.evt_ready_i = 1'b0;
    pulse(1); pulse(2); pulse(3); pulse(4);
    repeat (7) step();
    evt_if.evt_ready_i = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();

    // random traffic with occasional stalls, mask changes and clears
    for (int unsigned c = 0; c < 2000; c++) begin
      int unsigned np = $urandom_range(0, 3);
      for (int unsigned k = 0; k < np; k++) begin
        if ($urandom_range(0, 1) == 0) pulse($urandom_range(0, 11));
        else                           pulse($urandom_range(0, N_LINES - 1));
      end
      if (c % 300 == 0)
        for (int unsigned l = 0; l < N_LINES; l++) mask[l] = ($urandom_range(0, 7) != 0);
      if ((c / 100) % 3 == 1) evt_if.evt_ready_i = 1'b0;
      else                    evt_if.evt_ready_i = ($urandom_range(0, 3) != 0);
      lost_clr = ($urandom_range(0, 49) == 0);
      if (c == 1234) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    mask = '1;
    evt_if.evt_ready_i = 1'b1;
    repeat (N_LINES + 20) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
